fifo_wr_arb_ctrl: RTL and testbench

FIFO_WR_ARB_CTRL -- requirements
Module: fifo_wr_arb_ctrl

---
 rtl/fifo_wr_arb_ctrl.sv | 87 ++++++++
 tb/tb_fifo_wr_arb_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_ctrl.sv
// Two-producer round-robin write arbiter and pointer/flag controller for an external FIFO memory.
// Grants are combinational, so a write is accepted in the cycle it is requested. Refused producers hold req; rvalid follows an accepted read by one cycle.
module fifo_wr_arb_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   input  logic             rd_rq,
   output logic             mem_wr_rq,
   output logic [AW-1:0]    mem_waddr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_rd_rq,
   output logic [AW-1:0]    mem_raddr,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             rvalid,
   output logic             underflow
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_last;
   logic        r_rvalid;
   logic        r_underflow;

   logic        w_empty;
   logic        w_full;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_rd;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

   // r_last = 1 means producer 1 was served last, so producer 0 wins the next tie
   assign w_gnt0 = !w_full && req0 && (!req1 || r_last);
   assign w_gnt1 = !w_full && req1 && (!req0 || !r_last);
   assign w_rd   = rd_rq && !w_empty;

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign mem_wr_rq = w_gnt0 | w_gnt1;
   assign mem_wdata = w_gnt1 ? wdata1 : wdata0;
   assign mem_waddr = r_wptr[AW-1:0];
   assign mem_rd_rq = w_rd;
   assign mem_raddr = r_rptr[AW-1:0];
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_wptr - r_rptr;
   assign rvalid    = r_rvalid;
   // Sticky flag, but visible already in the offending cycle
   assign underflow = r_underflow | (rd_rq & w_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_last      <= 1'b1;
         r_rvalid    <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_wptr <= r_wptr + PTR_ONE;
            r_last <= w_gnt1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         r_rvalid <= w_rd;
         if (rd_rq && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: cycle vector table, hand sequences for reset and wrap,
// and a memory model with a data scoreboard checked whenever rvalid is high.
module tb_fifo_wr_arb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, rd_rq;
   logic [3:0] wdata0, wdata1;
   logic       gnt0, gnt1, mem_wr_rq, mem_rd_rq, full, empty, rvalid, underflow;
   logic [2:0] mem_waddr, mem_raddr;
   logic [3:0] mem_wdata;
   logic [3:0] count;

   int errors = 0;
   int checks = 0;
   int n_pop  = 0;

   always #5 clk = ~clk;

   fifo_wr_arb_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rd_rq(rd_rq),
      .mem_wr_rq(mem_wr_rq), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_rd_rq(mem_rd_rq), .mem_raddr(mem_raddr),
      .full(full), .empty(empty), .count(count),
      .rvalid(rvalid), .underflow(underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory with one-cycle registered read, as the controller expects
   logic [3:0] mem_m [8];
   logic [3:0] rdata_m;
   always @(posedge clk) begin
      if (mem_wr_rq) mem_m[mem_waddr] <= mem_wdata;
      if (mem_rd_rq) rdata_m <= mem_m[mem_raddr];
   end

   logic [3:0] sb_q[$];
   always @(negedge clk) begin
      if (rst_n && rvalid) begin
         n_pop++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdata: rvalid with nothing expected at %0t", $time);
         end else begin
            check("rdata", 32'(rdata_m), 32'(sb_q.pop_front()));
         end
      end
   end

   typedef struct {
      logic r0, r1, rd;
      logic g0, g1, mrd;
      logic [2:0] wa, ra;
      logic [3:0] cnt;
      logic fu, em, rv, uf;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r0, r1, rd, g0, g1, mrd, input int wa, ra, cnt,
                      input logic fu, em, rv, uf);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.rd = rd; v.g0 = g0; v.g1 = g1; v.mrd = mrd;
      v.wa = 3'(wa); v.ra = 3'(ra); v.cnt = 4'(cnt);
      v.fu = fu; v.em = em; v.rv = rv; v.uf = uf;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [21:0] act, exp;
      logic [3:0]  exp_wd;

      rst_n = 1'b0; req0 = 0; req1 = 0; rd_rq = 0; wdata0 = '0; wdata1 = '0;
      #1;
      check("reset_state", 32'({count, empty, full, underflow, rvalid, mem_wr_rq, mem_rd_rq}),
            32'({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //   r0 r1 rd  g0 g1 mrd  wa ra cnt  fu em rv uf
      add(1, 1, 0,  1, 0, 0,   0, 0, 0,   0, 1, 0, 0);
      add(1, 1, 0,  0, 1, 0,   1, 0, 1,   0, 0, 0, 0);
      add(1, 1, 0,  1, 0, 0,   2, 0, 2,   0, 0, 0, 0);
      add(1, 1, 0,  0, 1, 0,   3, 0, 3,   0, 0, 0, 0);
      for (int k = 4; k < 8; k++)
         add(1, 0, 0, 1, 0, 0, k, 0, k, 0, 0, 0, 0);
      add(1, 1, 0,  0, 0, 0,   0, 0, 8,   1, 0, 0, 0);
      add(0, 1, 1,  0, 0, 1,   0, 0, 8,   1, 0, 0, 0);
      add(1, 1, 0,  0, 1, 0,   0, 1, 7,   0, 0, 1, 0);
      for (int j = 0; j < 8; j++)
         add(0, 0, 1, 0, 0, 1, 1, (1 + j) % 8, 8 - j, logic'(j == 0), 0, logic'(j > 0), 0);
      add(1, 0, 1,  1, 0, 0,   1, 1, 0,   0, 1, 1, 1);
      add(0, 0, 0,  0, 0, 0,   2, 1, 1,   0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req0 = tbl[i].r0; req1 = tbl[i].r1; rd_rq = tbl[i].rd;
         wdata0 = 4'(i); wdata1 = 4'(i + 8);
         #1;
         exp_wd = tbl[i].g1 ? wdata1 : wdata0;
         exp = {tbl[i].g0, tbl[i].g1, tbl[i].g0 | tbl[i].g1, tbl[i].mrd, tbl[i].wa, tbl[i].ra,
                tbl[i].cnt, tbl[i].fu, tbl[i].em, tbl[i].rv, tbl[i].uf, exp_wd};
         act = {gnt0, gnt1, mem_wr_rq, mem_rd_rq, mem_waddr, mem_raddr,
                count, full, empty, rvalid, underflow, mem_wdata};
         check($sformatf("vec%0d", i), 32'(act), 32'(exp));
         if (tbl[i].g0) sb_q.push_back(wdata0);
         else if (tbl[i].g1) sb_q.push_back(wdata1);
      end

      // Fill to five entries, then pull reset between clock edges
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req0 = 1; req1 = 0; rd_rq = 0; wdata0 = 4'(12 + k);
         #1;
         check("fill_gnt", 32'(gnt0), 32'd1);
         sb_q.push_back(wdata0);
      end
      @(negedge clk);
      req0 = 0;
      #1;
      check("count5", 32'(count), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_flags", 32'({count, empty, full, underflow, rvalid}),
            32'({4'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req0 = 1; req1 = 1;
      #1;
      check("tie_after_reset", 32'({gnt0, gnt1}), 32'({1'b1, 1'b0}));
      #2;
      req0 = 0; req1 = 0;

      // Interleaved writes and reads across the address wrap
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req0 = 1; rd_rq = 0; wdata0 = 4'(i + 3);
         #1;
         check($sformatf("wrap_wr%0d", i), 32'({gnt0, mem_wr_rq, mem_waddr}),
               32'({1'b1, 1'b1, 3'(i)}));
         sb_q.push_back(wdata0);
         @(negedge clk);
         req0 = 0; rd_rq = 1;
         #1;
         check($sformatf("wrap_rd%0d", i), 32'({mem_rd_rq, mem_raddr}),
               32'({1'b1, 3'(i)}));
      end
      @(negedge clk);
      rd_rq = 0;
      #1;
      check("end_empty", 32'({empty, count}), 32'({1'b1, 4'd0}));
      @(negedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("pop_count", 32'(n_pop), 32'd21);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
